// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte-stream load, status and fetch-read signals of the instruction loader.
interface instruction_loader_if #(
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic              finish;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              overflow;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       instruction;
  modport master (
    output start, finish, byte_in, byte_valid, addr,
    input  byte_ready, load_busy, load_done, word_count, overflow, instruction
  );
  modport slave (
    input  start, finish, byte_in, byte_valid, addr,
    output byte_ready, load_busy, load_done, word_count, overflow, instruction
  );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: assembles an MSB-first byte stream into 32-bit words and serves them to a fetch port.
module instruction_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst_n,
  instruction_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
  state_t          state, state_n;
  logic [1:0]      idx;
  logic [23:0]     asm_q;
  logic [ADDR_W:0] wc;
  logic            ovf;
  logic            accept, last;
  logic [31:0]     mem [DEPTH];
  assign bus.byte_ready  = (state == LOAD) && !bus.start;
  assign bus.load_busy   = state == LOAD;
  assign bus.load_done   = state == DONE;
  assign bus.word_count  = wc;
  assign bus.overflow    = ovf;
  assign accept          = bus.byte_valid && bus.byte_ready;
  assign last            = accept && (idx == 2'd3);
  // Only words below word_count are valid; the array itself is never cleared.
  assign bus.instruction = ({1'b0, bus.addr} < wc) ? mem[bus.addr] : 32'h0;
  always_comb begin
    state_n = state;
    state_n = bus.start ? LOAD :
              (state == LOAD && (bus.finish || (last && wc == LAST_WORD))) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc    <= '0;
      idx   <= '0;
      ovf   <= 1'b0;
      asm_q <= '0;
    end else if (bus.start) begin
      wc  <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else if (state == LOAD) begin
      if (accept) begin
        asm_q <= {asm_q[15:0], bus.byte_in};
        idx   <= idx + 2'd1;
      end
      if (last) wc <= wc + 1'b1;
      if (bus.finish) idx <= '0;
    end else if (state == DONE && bus.byte_valid) begin
      ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (last) mem[wc[ADDR_W-1:0]] <= {asm_q, bus.byte_in};
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: table-driven vectors plus hand-written full-load and async-reset sequences.
module tb_instruction_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  instruction_loader_if #(.ADDR_W(5)) bus ();
  instruction_loader #(.DEPTH(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        st, fi, bv;
    logic [7:0]  b;
    logic [4:0]  a;
    logic        busy, done, ovf;
    logic [5:0]  wc;
    logic [31:0] ins;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic st, logic fi, logic bv, logic [7:0] b, logic [4:0] a,
                              logic busy, logic done, logic ovf, logic [5:0] wc, logic [31:0] ins);
    vec_t r;
    r.st = st; r.fi = fi; r.bv = bv; r.b = b; r.a = a;
    r.busy = busy; r.done = done; r.ovf = ovf; r.wc = wc; r.ins = ins;
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step(input logic st, input logic fi, input logic bv, input logic [7:0] b);
    @(negedge clk);
    bus.start = st; bus.finish = fi; bus.byte_valid = bv; bus.byte_in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.finish = 1'b0; bus.byte_valid = 1'b0;
  endtask
  function automatic logic [63:0] pack(logic ready, logic busy, logic done, logic ovf,
                                       logic [5:0] wc, logic [31:0] ins);
    return {22'd0, ready, busy, done, ovf, wc, ins};
  endfunction
  initial begin
    bus.start = 0; bus.finish = 0; bus.byte_valid = 0; bus.byte_in = 0; bus.addr = 0;
    v.push_back(mk(0,0,0,8'h00,0, 0,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h8C,0, 0,0,0,0,32'h0));
    v.push_back(mk(0,1,0,8'h00,0, 0,0,0,0,32'h0));
    v.push_back(mk(1,0,0,8'h00,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h8C,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h01,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h00,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h04,0, 1,0,0,1,32'h8C010004));
    v.push_back(mk(0,0,0,8'h00,0, 1,0,0,1,32'h8C010004));
    v.push_back(mk(0,0,1,8'h20,1, 1,0,0,1,32'h0));
    v.push_back(mk(0,0,1,8'h02,1, 1,0,0,1,32'h0));
    v.push_back(mk(0,0,1,8'h00,1, 1,0,0,1,32'h0));
    v.push_back(mk(0,0,1,8'h05,1, 1,0,0,2,32'h20020005));
    v.push_back(mk(0,0,0,8'h00,2, 1,0,0,2,32'h0));
    v.push_back(mk(0,0,0,8'h00,0, 1,0,0,2,32'h8C010004));
    v.push_back(mk(1,0,0,8'h00,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h11,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h22,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h33,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h44,0, 1,0,0,1,32'h11223344));
    v.push_back(mk(0,0,1,8'h55,1, 1,0,0,1,32'h0));
    v.push_back(mk(0,0,1,8'h66,1, 1,0,0,1,32'h0));
    v.push_back(mk(0,1,0,8'h00,1, 0,1,0,1,32'h0));
    v.push_back(mk(0,0,1,8'h77,0, 0,1,1,1,32'h11223344));
    v.push_back(mk(1,0,0,8'h00,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'hA1,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'hA2,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'hA3,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,1,1,8'hA4,0, 0,1,0,1,32'hA1A2A3A4));
    v.push_back(mk(1,0,0,8'h00,0, 1,0,0,0,32'h0));
    v.push_back(mk(1,0,1,8'h55,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h01,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h02,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h03,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h04,0, 1,0,0,1,32'h01020304));
    v.push_back(mk(0,0,1,8'hEE,0, 1,0,0,1,32'h01020304));
    v.push_back(mk(1,1,0,8'h00,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h09,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h08,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h07,0, 1,0,0,0,32'h0));
    v.push_back(mk(0,0,1,8'h06,0, 1,0,0,1,32'h09080706));
    // reset state, checked while rst_n is still low
    #12;
    foreach (v[i]) begin
    end
    bus.addr = 5'd0;  #1; chk("rst_addr0",  pack(bus.byte_ready, bus.load_busy, bus.load_done, bus.overflow, bus.word_count, bus.instruction), 64'd0);
    bus.addr = 5'd23; #1; chk("rst_addr23", pack(bus.byte_ready, bus.load_busy, bus.load_done, bus.overflow, bus.word_count, bus.instruction), 64'd0);
    bus.addr = 5'd31; #1; chk("rst_addr31", pack(bus.byte_ready, bus.load_busy, bus.load_done, bus.overflow, bus.word_count, bus.instruction), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      bus.addr = v[i].a;
      step(v[i].st, v[i].fi, v[i].bv, v[i].b);
      #1;
      chk($sformatf("vec%0d", i),
          pack(bus.byte_ready, bus.load_busy, bus.load_done, bus.overflow, bus.word_count, bus.instruction),
          pack(v[i].busy, v[i].busy, v[i].done, v[i].ovf, v[i].wc, v[i].ins));
    end
    // start held high in LOAD must mask byte_ready combinationally
    @(negedge clk);
    bus.start = 1'b1; #1;
    chk("ready_masked_by_start", {63'd0, bus.byte_ready}, 64'd0);
    bus.start = 1'b0; #1;
    chk("ready_in_load", {63'd0, bus.byte_ready}, 64'd1);
    // full 128-byte load
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 128; i++) begin
      step(0, 0, 1, 8'(i));
      if (i == 126) chk("not_done_at_127", {63'd0, bus.load_done}, 64'd0);
      if (i == 127) chk("done_at_128", {57'd0, bus.load_done, bus.word_count}, {57'd1, 6'd32});
    end
    bus.addr = 5'd31; #1; chk("full_addr31", {32'd0, bus.instruction}, {32'd0, 32'h7C7D7E7F});
    bus.addr = 5'd0;  #1; chk("full_addr0",  {32'd0, bus.instruction}, {32'd0, 32'h00010203});
    step(0, 0, 1, 8'hFF);
    bus.addr = 5'd31; #1;
    chk("overflow_set", {31'd0, bus.overflow, bus.load_done, bus.word_count, 25'd0},
        {31'd0, 1'b1, 1'b1, 6'd32, 25'd0});
    chk("overflow_addr31", {32'd0, bus.instruction}, {32'd0, 32'h7C7D7E7F});
    // async reset mid-load
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h31);
    step(0, 0, 1, 8'h32);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.addr = 5'd0; #1;
    chk("async_rst", pack(bus.byte_ready, bus.load_busy, bus.load_done, bus.overflow, bus.word_count, bus.instruction), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 1, 8'h12);
    #1;
    chk("idle_after_rst", pack(bus.byte_ready, bus.load_busy, bus.load_done, bus.overflow, bus.word_count, bus.instruction), 64'd0);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hAA);
    step(0, 0, 1, 8'hBB);
    step(0, 0, 1, 8'hCC);
    step(0, 0, 1, 8'hDD);
    bus.addr = 5'd0; #1;
    chk("reload_addr0", {26'd0, bus.word_count, bus.instruction}, {26'd0, 6'd1, 32'hAABBCCDD});
    bus.addr = 5'd1; #1;
    chk("reload_addr1", {32'd0, bus.instruction}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter: DEPTH, 32, number of 32-bit instruction words held.
REQ-002 Parameter: ADDR_W, 5, width of the read address (log2 DEPTH).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  one-cycle pulse; clears the load and enters LOAD.
REQ-006 Port: finish  input  1  one-cycle pulse; ends the load early.
REQ-007 Port: byte_in  input  8  instruction byte, most significant byte of each word first.
REQ-008 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-009 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: load_busy  output  1  high in state LOAD.
REQ-011 Port: load_done  output  1  high in state DONE.
REQ-012 Port: word_count  output  6  number of complete words written, range 0..32.
REQ-013 Port: overflow  output  1  sticky flag: a byte was offered while in DONE.
REQ-014 Port: addr  input  ADDR_W  read address from the fetch side.
REQ-015 Port: instruction  output  32  combinational read data for addr.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-017 IDLE SHALL go to LOAD on start, and SHALL ignore finish and byte_valid.
REQ-018 On entry to LOAD, word_count, the byte index (0..3) and overflow SHALL clear.
REQ-019 byte_ready SHALL equal (state==LOAD) && !start, as a combinational output.
REQ-020 A byte SHALL be accepted only in a cycle where byte_valid && byte_ready.
REQ-021 Accepted bytes SHALL shift into a 32-bit assembly register MSB-first: byte 0 goes to [31:24] and byte 3 goes to [7:0].
REQ-022 On the edge that accepts byte 3, the assembled word (including that byte) SHALL be written to mem[word_count[4:0]].
- On the same edge, word_count SHALL increment and the byte index SHALL wrap to 0.
REQ-023 When word_count reaches DEPTH (32), the FSM SHALL enter DONE on that same edge.
REQ-024 finish in LOAD SHALL enter DONE on the next edge.
- Any partial word (byte index != 0) SHALL be discarded and SHALL NOT be written.
- word_count SHALL be unchanged.
REQ-025 finish in the same cycle as an accepted byte 3 SHALL write that word first, then enter DONE.
REQ-026 start in LOAD SHALL restart the load: counters clear and any partial word is dropped; start SHALL take priority over finish.
REQ-027 DONE SHALL hold contents and word_count, and SHALL return to LOAD only on start.
REQ-028 byte_valid while in DONE SHALL set overflow; the byte SHALL be dropped and memory SHALL NOT change.
REQ-029 instruction SHALL equal mem[addr] when addr < word_count, and 32'h00000000 (NOP) otherwise, in every state.
REQ-030 Memory writes and reads SHALL use the same clock domain; a word written on edge N SHALL be readable from just after edge N.
REQ-031 The memory array SHALL NOT be reset; validity SHALL come only from word_count.

Reset
REQ-032 While rst_n = 0, the following SHALL hold immediately, independent of clk:
- state = IDLE
- word_count = 0, byte index = 0, overflow = 0
- byte_ready = 0, load_busy = 0, load_done = 0
- instruction = 0
REQ-033 Reset asserted in the middle of a load SHALL abandon the load; after release, every addr SHALL read 0 until new words are loaded.
REQ-034 The first operation after reset release SHALL require a start pulse.

Verification
REQ-035 Reset, then addr = 0, 23, 31 -> instruction = 0 for each; byte_ready = 0.
REQ-036 start, then bytes 8C,01,00,04 and 20,02,00,05 -> word_count = 2; addr 0 reads 8C010004; addr 1 reads 20020005; addr 2 reads 0.
REQ-037 start, 128 bytes with value = index -> load_done at the 128th accept; addr 31 reads 7C7D7E7F; byte_valid afterwards -> overflow = 1 and addr 31 is unchanged.
REQ-038 start, 6 bytes, then finish -> DONE; word_count = 1; addr 1 reads 0 (partial word dropped).
REQ-039 start, 2 bytes, then rst_n low for 1 cycle between edges -> outputs clear asynchronously; after start and 4 bytes AABBCCDD, addr 0 reads AABBCCDD.
REQ-040 byte 3 accepted in the same cycle as finish -> the word is written and word_count increments; start together with byte_valid -> the byte is not accepted and word_count = 0.
